// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared constants and FSM encoding for the RRF allocation controller.
package rrf_alloc_ctrl_pkg;

    localparam int unsigned RRF_NUM     = 64;
    localparam int unsigned RRF_SEL     = 6;
    localparam int unsigned RECOVER_CYC = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned FREE_W      = RRF_SEL + 1;
    localparam int unsigned CALC_W      = RRF_SEL + 2;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } rrf_state_e;

endpackage

// File: rtl/rrf_alloc_ctrl_recover_timer.sv
// Loadable down-counter that times the post-mispredict dispatch hold.
module rrf_recover_timer
    import rrf_alloc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    // Reload wins over decrement; counter parks at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF/ROB entry allocation and mispredict recovery controller.
// Optional statistics outputs are built when RRF_ALLOC_STATS_EN is defined.
module rrf_alloc_ctrl
    import rrf_alloc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_num,
    input  logic               stall_dp,
    input  logic [1:0]         comnum,
    input  logic [RRF_SEL-1:0] comptr,
    input  logic               prmiss,
    output logic               alloc_ok,
    output logic               dp1,
    output logic               dp2,
    output logic [RRF_SEL-1:0] dp1_addr,
    output logic [RRF_SEL-1:0] dp2_addr,
    output logic [RRF_SEL-1:0] dispatchptr,
    output logic [RRF_SEL:0]   rrf_freenum,
    output logic               recovering,
    output logic               proto_err
`ifdef RRF_ALLOC_STATS_EN
    ,
    output logic [RRF_SEL:0]   occ_hwm,
    output logic [31:0]        stall_full_cnt
`endif
);

    rrf_state_e         state_q, state_d;
    logic [RRF_SEL-1:0] ptr_d;
    logic [FREE_W-1:0]  free_d;
    logic               err_d;
    logic               tmr_load;
    logic               tmr_done_c;
    logic [1:0]         alloc_num;
    logic [CALC_W-1:0]  free_calc;
    logic               over_release;
    logic               over_full;
    logic               bad_req;

    rrf_recover_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (CNT_W'(RECOVER_CYC - 1)),
        .dec      (state_q == ST_RECOVER),
        .done_c   (tmr_done_c)
    );

    // All-or-nothing grant; held low while reset is asserted.
    assign alloc_ok = reset & (state_q == ST_RUN) & ~prmiss & ~stall_dp
                    & (req_num != 2'd0) & (rrf_freenum >= FREE_W'(req_num));
    assign dp1      = alloc_ok & (req_num >= 2'd1);
    assign dp2      = alloc_ok & (req_num == 2'd2);
    assign dp1_addr = reset ? dispatchptr : '0;
    assign dp2_addr = reset ? (dispatchptr + RRF_SEL'(1)) : '0;

    assign alloc_num    = {1'b0, dp1} + {1'b0, dp2};
    assign free_calc    = CALC_W'(rrf_freenum) - CALC_W'(alloc_num) + CALC_W'(comnum);
    assign over_release = CALC_W'(comnum) > (CALC_W'(RRF_NUM) - CALC_W'(rrf_freenum));
    assign over_full    = free_calc > CALC_W'(RRF_NUM);
    assign bad_req      = (req_num == 2'd3);
    assign recovering   = (state_q == ST_RECOVER);

    // Next-state: mispredict restores the pointer and frees everything.
    always_comb begin
        state_d  = state_q;
        ptr_d    = dispatchptr;
        free_d   = rrf_freenum;
        err_d    = proto_err | bad_req;
        tmr_load = 1'b0;
        if (prmiss) begin
            state_d  = ST_RECOVER;
            ptr_d    = comptr;
            free_d   = FREE_W'(RRF_NUM);
            tmr_load = 1'b1;
        end else begin
            ptr_d = dispatchptr + RRF_SEL'(alloc_num);
            if (over_release || over_full) begin
                err_d = 1'b1;
            end
            free_d = over_full ? FREE_W'(RRF_NUM) : FREE_W'(free_calc);
            if ((state_q == ST_RECOVER) && tmr_done_c) begin
                state_d = ST_RUN;
            end
        end
    end

    // State, pointer, free count and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            dispatchptr <= '0;
            rrf_freenum <= FREE_W'(RRF_NUM);
            proto_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dispatchptr <= ptr_d;
            rrf_freenum <= free_d;
            proto_err   <= err_d;
        end
    end

`ifdef RRF_ALLOC_STATS_EN
    logic [FREE_W-1:0] occ_c;
    logic              full_stall_c;

    assign occ_c        = FREE_W'(RRF_NUM) - rrf_freenum;
    assign full_stall_c = (state_q == ST_RUN) && (req_num != 2'd0)
                        && (rrf_freenum < FREE_W'(req_num));

    // Occupancy high-water mark and saturating full-stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_hwm        <= '0;
            stall_full_cnt <= '0;
        end else begin
            if (occ_c > occ_hwm) begin
                occ_hwm <= occ_c;
            end
            if (full_stall_c && (stall_full_cnt != '1)) begin
                stall_full_cnt <= stall_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
